// File: rtl/pq_ctrl.sv
// pq_ctrl: handshake front end for an external priority queue.
// Producers push keys through a valid/ready port and consumers drain the
// queue head through a one-entry output buffer. The queue itself is
// driven by one-hot loadIn / shiftOut / clear commands and reports its
// head on 'top', which is settled the cycle after any command.
module pq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 6
) (
    input  logic             ck,
    input  logic             r,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] newVal,
    output logic             loadIn,
    output logic             shiftOut,
    output logic             clear,
    input  logic [WIDTH-1:0] top
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    count_r;
    logic             pop_valid_r;
    logic [WIDTH-1:0] pop_data_r;

    logic             clear_s;
    logic             pop_issue_s;
    logic             push_ready_s;
    logic             load_s;

    // Command decode: pop wins over push, flush blocks both, clear only while resynchronising the queue.
    always_comb begin
        clear_s      = 1'b0;
        pop_issue_s  = 1'b0;
        push_ready_s = 1'b0;
        case (state_r)
            INIT, FLUSH: begin
                // Gated by r so that no command leaves the block while reset is held.
                clear_s = r;
            end
            RUN: begin
                pop_issue_s  = r & ~flush & (count_r != ZERO_C) & (~pop_valid_r | pop_ready);
                push_ready_s = r & ~flush & (count_r < DEPTH_C) & ~pop_issue_s;
            end
            default: begin
                clear_s      = 1'b0;
                pop_issue_s  = 1'b0;
                push_ready_s = 1'b0;
            end
        endcase
        load_s = push_valid & push_ready_s;
    end

    // Controller state: FSM, occupancy counter and the registered pop buffer.
    always_ff @(posedge ck or negedge r) begin
        if (!r) begin
            state_r     <= INIT;
            count_r     <= ZERO_C;
            pop_valid_r <= 1'b0;
            pop_data_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                INIT: begin
                    state_r <= RUN;
                    count_r <= ZERO_C;
                end
                FLUSH: begin
                    // A flush arriving here is absorbed: the queue is being cleared already.
                    state_r <= RUN;
                    count_r <= ZERO_C;
                end
                RUN: begin
                    if (flush) begin
                        state_r     <= FLUSH;
                        pop_valid_r <= 1'b0;
                    end else if (pop_issue_s) begin
                        count_r     <= count_r - ONE_C;
                        pop_valid_r <= 1'b1;
                        pop_data_r  <= top;
                    end else begin
                        if (load_s) begin
                            count_r <= count_r + ONE_C;
                        end
                        if (pop_ready) begin
                            pop_valid_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: recover through a clear cycle.
                    state_r     <= INIT;
                    count_r     <= ZERO_C;
                    pop_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign push_ready = push_ready_s;
    assign loadIn     = load_s;
    assign shiftOut   = pop_issue_s;
    assign clear      = clear_s;
    assign newVal     = push_data;
    assign pop_valid  = pop_valid_r;
    assign pop_data   = pop_data_r;
    assign full       = (count_r == DEPTH_C);
    assign empty      = (count_r == ZERO_C);

endmodule

// File: tb/tb_pq_ctrl.sv
// Bench for pq_ctrl: an ideal min-first priority queue sits behind the
// command port, directed scenarios walk the main behaviours, and a
// randomized run is scored against an abstract model of the controller.
module tb_pq_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 6;

    logic             ck = 1'b0;
    logic             r = 1'b0;
    logic             push_valid = 1'b0;
    logic             push_ready;
    logic [WIDTH-1:0] push_data = 8'h00;
    logic             pop_valid;
    logic             pop_ready = 1'b0;
    logic [WIDTH-1:0] pop_data;
    logic             flush = 1'b0;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] newVal;
    logic             loadIn;
    logic             shiftOut;
    logic             clear;
    logic [WIDTH-1:0] top = 8'h00;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] pq[$];

    pq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .ck(ck), .r(r),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
        .flush(flush), .full(full), .empty(empty),
        .newVal(newVal), .loadIn(loadIn), .shiftOut(shiftOut), .clear(clear),
        .top(top)
    );

    always #5 ck = ~ck;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance one clock; the external queue reacts to the commands seen before the edge.
    task automatic tick();
        logic l, s, c;
        logic [WIDTH-1:0] d;
        int i;
        l = loadIn; s = shiftOut; c = clear; d = newVal;
        @(posedge ck);
        #1;
        if (!r || c) pq.delete();
        else if (l) begin
            i = 0;
            while (i < pq.size() && pq[i] <= d) i++;
            pq.insert(i, d);
        end else if (s) begin
            void'(pq.pop_front());
        end
        top = (pq.size() > 0) ? pq[0] : 8'h00;
    endtask

    task automatic test_reset();
        r = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0; push_data = 8'h00;
        pq.delete(); top = 8'h00;
        @(posedge ck); @(posedge ck); #1;
        checks++; if (clear !== 1'b0) begin failures++; $display("FAIL rst_clear: got %b want 0", clear); end
        checks++; if (loadIn !== 1'b0 || shiftOut !== 1'b0) begin failures++; $display("FAIL rst_cmds: got %b%b want 00", loadIn, shiftOut); end
        checks++; if (push_ready !== 1'b0) begin failures++; $display("FAIL rst_push_ready: got %b want 0", push_ready); end
        checks++; if (full !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL rst_full_empty: got %b%b want 01", full, empty); end
        checks++; if (pop_valid !== 1'b0 || pop_data !== 8'h00) begin failures++; $display("FAIL rst_pop: got %b/%h want 0/00", pop_valid, pop_data); end
        r = 1'b1;
        #1;
        checks++; if (clear !== 1'b1) begin failures++; $display("FAIL init_clear: got %b want 1", clear); end
        checks++; if (push_ready !== 1'b0) begin failures++; $display("FAIL init_push_ready: got %b want 0", push_ready); end
        tick();
        checks++; if (clear !== 1'b0) begin failures++; $display("FAIL run_clear: got %b want 0", clear); end
        checks++; if (empty !== 1'b1 || push_ready !== 1'b1) begin failures++; $display("FAIL run_ready: got empty=%b push_ready=%b want 1,1", empty, push_ready); end
    endtask

    task automatic test_push_pop();
        pop_ready = 1'b0; push_valid = 1'b1; push_data = 8'h30;
        #1;
        checks++; if (loadIn !== 1'b1 || shiftOut !== 1'b0) begin failures++; $display("FAIL pp_load30: got %b%b want 10", loadIn, shiftOut); end
        tick();
        push_data = 8'h10;
        #1;
        checks++; if (shiftOut !== 1'b1 || loadIn !== 1'b0 || push_ready !== 1'b0) begin failures++; $display("FAIL pp_autopop: got s=%b l=%b pr=%b want 1,0,0", shiftOut, loadIn, push_ready); end
        tick();
        checks++; if (pop_valid !== 1'b1 || pop_data !== 8'h30 || empty !== 1'b1) begin failures++; $display("FAIL pp_first: got %b/%h e=%b want 1/30 e=1", pop_valid, pop_data, empty); end
        checks++; if (loadIn !== 1'b1) begin failures++; $display("FAIL pp_load10: got %b want 1", loadIn); end
        tick();
        push_data = 8'h50;
        #1;
        checks++; if (loadIn !== 1'b1 || shiftOut !== 1'b0) begin failures++; $display("FAIL pp_load50: got %b%b want 10", loadIn, shiftOut); end
        tick();
        push_valid = 1'b0;
        #1;
        checks++; if (pop_data !== 8'h30 || pop_valid !== 1'b1 || shiftOut !== 1'b0) begin failures++; $display("FAIL pp_hold: got %b/%h s=%b want 1/30 s=0", pop_valid, pop_data, shiftOut); end
        pop_ready = 1'b1;
        #1;
        checks++; if (shiftOut !== 1'b1) begin failures++; $display("FAIL pp_pop2: got %b want 1", shiftOut); end
        tick();
        checks++; if (pop_data !== 8'h10) begin failures++; $display("FAIL pp_data10: got %h want 10", pop_data); end
        tick();
        checks++; if (pop_data !== 8'h50 || empty !== 1'b1) begin failures++; $display("FAIL pp_data50: got %h e=%b want 50 e=1", pop_data, empty); end
        #1;
        checks++; if (shiftOut !== 1'b0) begin failures++; $display("FAIL pp_nopop_empty: got %b want 0", shiftOut); end
        tick();
        checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL pp_drained: got %b want 0", pop_valid); end
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] keys[8];
        logic [WIDTH-1:0] srt[6];
        logic [WIDTH-1:0] t;
        logic l;
        int idx, both;
        for (int i = 0; i < 8; i++) keys[i] = WIDTH'($urandom_range(0, 255));
        pop_ready = 1'b0; push_valid = 1'b1; idx = 0; both = 0;
        for (int cyc = 0; cyc < 30 && full !== 1'b1; cyc++) begin
            push_data = keys[idx];
            #1;
            l = loadIn;
            if (loadIn && shiftOut) both++;
            tick();
            if (l) idx++;
        end
        push_data = keys[7];
        #1;
        checks++; if (both != 0) begin failures++; $display("FAIL full_onehot: got %0d overlaps want 0", both); end
        checks++; if (idx != 7) begin failures++; $display("FAIL full_loads: got %0d want 7", idx); end
        checks++; if (full !== 1'b1 || push_ready !== 1'b0 || loadIn !== 1'b0) begin failures++; $display("FAIL full_flags: got f=%b pr=%b l=%b want 1,0,0", full, push_ready, loadIn); end
        checks++; if (pop_valid !== 1'b1 || pop_data !== keys[0]) begin failures++; $display("FAIL full_head: got %b/%h want 1/%h", pop_valid, pop_data, keys[0]); end
        tick();
        #1;
        checks++; if (loadIn !== 1'b0) begin failures++; $display("FAIL full_seventh_waits: got %b want 0", loadIn); end
        for (int i = 0; i < 6; i++) srt[i] = keys[i + 1];
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 5 - i; j++)
                if (srt[j] > srt[j + 1]) begin t = srt[j]; srt[j] = srt[j + 1]; srt[j + 1] = t; end
        push_valid = 1'b0; pop_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (shiftOut !== 1'b1) begin failures++; $display("FAIL drain_pop%0d: got %b want 1", i, shiftOut); end
            tick();
            checks++; if (pop_data !== srt[i]) begin failures++; $display("FAIL drain_key%0d: got %h want %h", i, pop_data, srt[i]); end
        end
        tick();
        checks++; if (pop_valid !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL drain_end: got pv=%b e=%b want 0,1", pop_valid, empty); end
    endtask

    task automatic test_back_to_back();
        logic l;
        int loads;
        pop_ready = 1'b0; push_valid = 1'b1; loads = 0;
        for (int cyc = 0; cyc < 20 && loads < 4; cyc++) begin
            push_data = WIDTH'($urandom_range(0, 255));
            #1;
            l = loadIn;
            tick();
            if (l) loads++;
        end
        checks++; if (loads != 4) begin failures++; $display("FAIL b2b_setup: got %0d loads want 4", loads); end
        push_data = 8'h77; pop_ready = 1'b1;
        #1;
        checks++; if (shiftOut !== 1'b1 || loadIn !== 1'b0 || push_ready !== 1'b0) begin failures++; $display("FAIL b2b_pop_wins: got s=%b l=%b pr=%b want 1,0,0", shiftOut, loadIn, push_ready); end
        tick();
        pop_ready = 1'b0;
        #1;
        checks++; if (loadIn !== 1'b1 || shiftOut !== 1'b0) begin failures++; $display("FAIL b2b_push_next: got l=%b s=%b want 1,0", loadIn, shiftOut); end
        tick();
    endtask

    task automatic test_flush();
        push_valid = 1'b1; push_data = 8'h05; pop_ready = 1'b0;
        #1;
        checks++; if (loadIn !== 1'b1) begin failures++; $display("FAIL fl_fill: got %b want 1", loadIn); end
        tick();
        flush = 1'b1; pop_ready = 1'b1;
        #1;
        checks++; if (pop_valid !== 1'b1 || empty !== 1'b0) begin failures++; $display("FAIL fl_pre: got pv=%b e=%b want 1,0", pop_valid, empty); end
        checks++; if (clear !== 1'b0 || shiftOut !== 1'b0 || loadIn !== 1'b0 || push_ready !== 1'b0) begin failures++; $display("FAIL fl_req_cmds: got c=%b s=%b l=%b pr=%b want 0,0,0,0", clear, shiftOut, loadIn, push_ready); end
        tick();
        #1;
        checks++; if (clear !== 1'b1 || shiftOut !== 1'b0 || loadIn !== 1'b0 || push_ready !== 1'b0) begin failures++; $display("FAIL fl_clear_cycle: got c=%b s=%b l=%b pr=%b want 1,0,0,0", clear, shiftOut, loadIn, push_ready); end
        checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL fl_pop_dropped: got %b want 0", pop_valid); end
        tick();
        flush = 1'b0; push_valid = 1'b0;
        #1;
        checks++; if (clear !== 1'b0 || empty !== 1'b1 || push_ready !== 1'b1 || pop_valid !== 1'b0) begin failures++; $display("FAIL fl_after: got c=%b e=%b pr=%b pv=%b want 0,1,1,0", clear, empty, push_ready, pop_valid); end
        checks++; if (pq.size() != 0) begin failures++; $display("FAIL fl_queue_cleared: got %0d entries want 0", pq.size()); end
    endtask

    task automatic test_mid_reset();
        push_valid = 1'b1; pop_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_data = WIDTH'($urandom_range(0, 255));
            #1;
            tick();
        end
        checks++; if (pop_valid !== 1'b1 || empty !== 1'b0) begin failures++; $display("FAIL mr_pre: got pv=%b e=%b want 1,0", pop_valid, empty); end
        #2;
        r = 1'b0; pq.delete(); top = 8'h00;
        #1;
        checks++; if (pop_valid !== 1'b0 || pop_data !== 8'h00 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL mr_state: got pv=%b pd=%h e=%b f=%b want 0,00,1,0", pop_valid, pop_data, empty, full); end
        checks++; if (loadIn !== 1'b0 || shiftOut !== 1'b0 || clear !== 1'b0 || push_ready !== 1'b0) begin failures++; $display("FAIL mr_cmds: got l=%b s=%b c=%b pr=%b want 0,0,0,0", loadIn, shiftOut, clear, push_ready); end
        @(posedge ck); #1;
        r = 1'b1; push_valid = 1'b0;
        #1;
        checks++; if (clear !== 1'b1) begin failures++; $display("FAIL mr_clear: got %b want 1", clear); end
        tick();
        checks++; if (clear !== 1'b0 || push_ready !== 1'b1 || empty !== 1'b1) begin failures++; $display("FAIL mr_run: got c=%b pr=%b e=%b want 0,1,1", clear, push_ready, empty); end
    endtask

    task automatic test_random();
        int mq[$];
        logic m_clearing, m_pv;
        logic [WIDTH-1:0] m_pd;
        logic e_pop, e_pr, e_ld;
        int mi;
        m_clearing = 1'b0; m_pv = 1'b0; m_pd = 8'h00;
        for (int cyc = 0; cyc < 500; cyc++) begin
            push_valid = ($urandom_range(0, 3) != 0);
            pop_ready  = ($urandom_range(0, 1) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            push_data  = WIDTH'($urandom_range(0, 255));
            #1;
            e_pop = !m_clearing && !flush && mq.size() > 0 && (!m_pv || pop_ready);
            e_pr  = !m_clearing && !flush && mq.size() < DEPTH && !e_pop;
            e_ld  = push_valid && e_pr;
            checks++; if (clear !== m_clearing) begin failures++; $display("FAIL rnd_clear c%0d: got %b want %b", cyc, clear, m_clearing); end
            checks++; if (shiftOut !== e_pop) begin failures++; $display("FAIL rnd_shift c%0d: got %b want %b", cyc, shiftOut, e_pop); end
            checks++; if (push_ready !== e_pr) begin failures++; $display("FAIL rnd_push_ready c%0d: got %b want %b", cyc, push_ready, e_pr); end
            checks++; if (loadIn !== e_ld) begin failures++; $display("FAIL rnd_load c%0d: got %b want %b", cyc, loadIn, e_ld); end
            checks++; if (full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin failures++; $display("FAIL rnd_level c%0d: got f=%b e=%b for %0d entries", cyc, full, empty, mq.size()); end
            checks++; if (pop_valid !== m_pv) begin failures++; $display("FAIL rnd_pop_valid c%0d: got %b want %b", cyc, pop_valid, m_pv); end
            if (m_pv) begin
                checks++; if (pop_data !== m_pd) begin failures++; $display("FAIL rnd_pop_data c%0d: got %h want %h", cyc, pop_data, m_pd); end
            end
            checks++; if (newVal !== push_data) begin failures++; $display("FAIL rnd_newval c%0d: got %h want %h", cyc, newVal, push_data); end
            tick();
            if (m_clearing) begin
                m_clearing = 1'b0;
                mq.delete();
            end else if (flush) begin
                m_clearing = 1'b1;
                m_pv = 1'b0;
            end else if (e_pop) begin
                mi = 0;
                for (int k = 1; k < mq.size(); k++) if (mq[k] < mq[mi]) mi = k;
                m_pd = WIDTH'(mq[mi]);
                mq.delete(mi);
                m_pv = 1'b1;
            end else begin
                if (e_ld) mq.push_back(int'(push_data));
                if (pop_ready) m_pv = 1'b0;
            end
        end
        flush = 1'b0; push_valid = 1'b0;
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_push_pop();
        test_full();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        test_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
